// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   Far-end model of the single-bit SPI status-register subset of a
//   W25Q64CV flash.  Decodes Write Enable (06h), Write Disable (04h),
//   Write Status Register (01h) and Read Status Register 1/2 (05h/35h),
//   and models WEL/BUSY so an initiator's poll loop ends realistically.
//   The SPI pins are oversampled on ACLK (SPI mode 0, MSB first).
//
// Ports
//   ACLK      system clock, all logic on the rising edge
//   ARESETn   asynchronous active-low reset
//   sclk      SPI clock from the initiator (asynchronous to ACLK)
//   cs_n      chip select, active-low
//   mosi      serial data from the initiator
//   miso      serial data to the initiator
//   miso_oe   drive enable for miso (IO1 is tristated when 0)
//   sr1       status register 1 {SRP0,SEC,TB,BP2,BP1,BP0,WEL,BUSY}
//   sr2       status register 2 (bit 1 = QE)
//   cmd_done  one-cycle pulse when cs_n deasserts after a recognised opcode
module spi_flash_responder #(
  parameter int         BUSY_CYCLES = 64,
  parameter logic [7:0] SR2_INIT    = 8'h00
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] sr1,
  output logic [7:0] sr2,
  output logic       cmd_done
);

  localparam int             CNT_W     = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);
  localparam logic [7:0]     OP_WREN   = 8'h06;
  localparam logic [7:0]     OP_WRDI   = 8'h04;
  localparam logic [7:0]     OP_WRSR   = 8'h01;
  localparam logic [7:0]     OP_RDSR1  = 8'h05;
  localparam logic [7:0]     OP_RDSR2  = 8'h35;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPCODE, ST_WSR_DATA, ST_READ_OUT, ST_IGNORE
  } state_t;

  function automatic logic is_known(input logic [7:0] op);
    return (op == OP_WREN) || (op == OP_WRDI) || (op == OP_WRSR) ||
           (op == OP_RDSR1) || (op == OP_RDSR2);
  endfunction

  // Synchronizers: stage [0] and [1] form the 2-flop synchronizer, stage [2]
  // holds the previous synchronized value for edge detection.  cs_n resets
  // to "low" so a transaction already in flight at reset release never
  // produces a falling edge; a real high phase must be seen first.
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             recog_q, recog_d;
  logic             src_q, src_d;
  logic [2:0]       rd_idx_q, rd_idx_d;
  logic             miso_q, miso_d;
  logic             miso_oe_q, miso_oe_d;
  logic             cmd_done_q, cmd_done_d;
  logic [7:0]       sr1_q, sr1_d;
  logic [7:0]       sr2_q, sr2_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       snap_q, snap_d;
  logic [5:0]       wsr1_q, wsr1_d;
  logic [7:0]       wsr2_q, wsr2_d;

  logic [7:0] byte_v;
  logic [7:0] live_v;
  assign byte_v = {shift_q[6:0], mosi_s};
  assign live_v = src_q ? sr2_q : sr1_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    recog_d    = recog_q;
    src_d      = src_q;
    rd_idx_d   = rd_idx_q;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    cmd_done_d = 1'b0;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    busy_cnt_d = busy_cnt_q;
    shift_d    = shift_q;
    snap_d     = snap_q;
    wsr1_d     = wsr1_q;
    wsr2_d     = wsr2_q;

    // BUSY and WEL drop together on the cycle the counter reaches zero.
    if (sr1_q[0]) begin
      if (busy_cnt_q <= CNT_W'(1)) begin
        busy_cnt_d = '0;
        sr1_d[1:0] = 2'b00;
      end else begin
        busy_cnt_d = busy_cnt_q - CNT_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = 3'd7;
        shift_d    = 8'h00;
        byte_cnt_d = 2'd0;
        recog_d    = 1'b0;
        miso_d     = 1'b0;
        miso_oe_d  = 1'b0;
        if (cs_fall) state_d = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (sclk_rise) begin
          shift_d   = byte_v;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            recog_d = is_known(byte_v);
            state_d = ST_IGNORE;
            // While busy only the status reads are honoured.
            if (!sr1_q[0] || byte_v == OP_RDSR1 || byte_v == OP_RDSR2) begin
              case (byte_v)
                OP_WREN: sr1_d[1] = 1'b1;
                OP_WRDI: sr1_d[1] = 1'b0;
                OP_WRSR: if (sr1_q[1]) state_d = ST_WSR_DATA;
                OP_RDSR1, OP_RDSR2: begin
                  state_d  = ST_READ_OUT;
                  src_d    = (byte_v == OP_RDSR2);
                  rd_idx_d = 3'd7;
                end
                default: ;
              endcase
            end
          end
        end
      end
      ST_WSR_DATA: begin
        // Only complete bytes are kept; bytes past the second are dropped.
        if (sclk_rise) begin
          shift_d   = byte_v;
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            if (byte_cnt_q == 2'd0) begin
              wsr1_d     = byte_v[7:2];
              byte_cnt_d = 2'd1;
            end else if (byte_cnt_q == 2'd1) begin
              wsr2_d     = byte_v;
              byte_cnt_d = 2'd2;
            end
          end
        end
      end
      ST_READ_OUT: begin
        // The register is sampled live at every bit 7 so a poll sees BUSY
        // clear mid-transaction; the other bits come from that snapshot.
        if (sclk_fall) begin
          miso_oe_d = 1'b1;
          rd_idx_d  = rd_idx_q - 3'd1;
          if (rd_idx_q == 3'd7) begin
            miso_d = live_v[7];
            snap_d = live_v;
          end else begin
            miso_d = snap_q[rd_idx_q];
          end
        end
      end
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over everything and is the only point a write commits.
    if (cs_rise) begin
      state_d    = ST_IDLE;
      miso_d     = 1'b0;
      miso_oe_d  = 1'b0;
      cmd_done_d = recog_q;
      if (state_q == ST_WSR_DATA && byte_cnt_q != 2'd0) begin
        sr1_d      = {wsr1_q, 2'b11};
        busy_cnt_d = BUSY_LOAD;
        if (byte_cnt_q == 2'd2) sr2_d = wsr2_q;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd7;
      byte_cnt_q <= 2'd0;
      recog_q    <= 1'b0;
      src_q      <= 1'b0;
      rd_idx_q   <= 3'd7;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      cmd_done_q <= 1'b0;
      sr1_q      <= 8'h00;
      sr2_q      <= SR2_INIT;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      recog_q    <= recog_d;
      src_q      <= src_d;
      rd_idx_q   <= rd_idx_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      cmd_done_q <= cmd_done_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Shift and staging data; always (re)initialised by the control path
  // before it is consumed, so no reset is needed.
  always_ff @(posedge ACLK) begin
    shift_q <= shift_d;
    snap_q  <= snap_d;
    wsr1_q  <= wsr1_d;
    wsr2_q  <= wsr2_d;
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign sr1      = sr1_q;
  assign sr2      = sr2_q;
  assign cmd_done = cmd_done_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Testbench for spi_flash_responder: directed scenarios plus randomized
// transactions checked against a transaction-level status-register model.
module tb_spi_flash_responder;

  localparam int         BC   = 120;
  localparam logic [7:0] SR2I = 8'h40;

  logic       ACLK    = 1'b0;
  logic       ARESETn = 1'b0;
  logic       sclk    = 1'b0;
  logic       cs_n    = 1'b1;
  logic       mosi    = 1'b0;
  logic       miso, miso_oe, cmd_done;
  logic [7:0] sr1, sr2;

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;
  int oe_cnt = 0;
  int busy_run = 0;
  int busy_len = 0;

  // Model of the architectural status registers, valid once BUSY has ended.
  logic [7:0] m_sr1, m_sr2;

  spi_flash_responder #(.BUSY_CYCLES(BC), .SR2_INIT(SR2I)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .sr1(sr1), .sr2(sr2), .cmd_done(cmd_done)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (cmd_done === 1'b1) cmd_cnt++;
    if (miso_oe === 1'b1) oe_cnt++;
    if (sr1[0] === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic spi_begin(input int half);
    @(negedge ACLK);
    cs_n = 1'b0;
    sclk = 1'b0;
    repeat (half) @(negedge ACLK);
  endtask

  task automatic spi_bits(input logic [63:0] tx, input int n, input int half,
                          output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[n-1-i];
      repeat (half) @(negedge ACLK);
      rx = {rx[62:0], miso};
      sclk = 1'b1;
      repeat (half) @(negedge ACLK);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end(input int half);
    repeat (half) @(negedge ACLK);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge ACLK);
  endtask

  task automatic spi_xfer(input logic [63:0] tx, input int n, input int half,
                          output logic [63:0] rx);
    spi_begin(half);
    spi_bits(tx, n, half, rx);
    spi_end(half);
  endtask

  // Applies one complete transaction (started while not busy) to the model.
  // m_sr1 ends up holding the value after any BUSY period has finished.
  task automatic model_txn(input logic [63:0] tx, input int nbits,
                           output int exp_cmd, output logic committed,
                           output logic [7:0] rd_val);
    logic [7:0] op;
    int nb;
    exp_cmd = 0; committed = 1'b0; rd_val = 8'h00;
    if (nbits >= 8) begin
      op = tx[nbits-1 -: 8];
      if (op inside {8'h06, 8'h04, 8'h01, 8'h05, 8'h35}) exp_cmd = 1;
      nb = (nbits - 8) / 8;
      if (nb > 2) nb = 2;
      case (op)
        8'h06: m_sr1[1] = 1'b1;
        8'h04: m_sr1[1] = 1'b0;
        8'h01: if (m_sr1[1] && nb >= 1) begin
          m_sr1[7:2] = tx[nbits-9 -: 6];
          if (nb == 2) m_sr2 = tx[nbits-17 -: 8];
          m_sr1[1] = 1'b0;
          committed = 1'b1;
        end
        8'h05: rd_val = m_sr1;
        8'h35: rd_val = m_sr2;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
    checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_cmd_done: got %b want 0", cmd_done); end
    ARESETn = 1'b1;
    m_sr1 = 8'h00; m_sr2 = SR2I;
    repeat (5) @(negedge ACLK);
    checks++; if (sr1 !== 8'h00) begin errors++; $display("FAIL reset_sr1: got %h want 00", sr1); end
    checks++; if (sr2 !== SR2I) begin errors++; $display("FAIL reset_sr2: got %h want %h", sr2, SR2I); end
  endtask

  task automatic test_write_poll();
    logic [63:0] rx; int ec, c0; logic cm; logic [7:0] rv;
    c0 = cmd_cnt;
    model_txn(64'h06, 8, ec, cm, rv);
    spi_xfer(64'h06, 8, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL wren_sr1: got %h want %h", sr1, m_sr1); end
    checks++; if (cmd_cnt - c0 != ec) begin errors++; $display("FAIL wren_cmd_done: got %0d want %0d", cmd_cnt - c0, ec); end
    model_txn(64'h010202, 24, ec, cm, rv);
    spi_xfer(64'h010202, 24, 5, rx);
    checks++; if (sr1 !== (m_sr1 | 8'h03)) begin errors++; $display("FAIL wsr16_sr1_busy: got %h want %h", sr1, m_sr1 | 8'h03); end
    checks++; if (sr2 !== m_sr2) begin errors++; $display("FAIL wsr16_sr2: got %h want %h", sr2, m_sr2); end
    model_txn(64'h05000000, 32, ec, cm, rv);
    spi_xfer(64'h05000000, 32, 5, rx);
    checks++; if (rx[23:16] !== (m_sr1 | 8'h03)) begin errors++; $display("FAIL poll_first: got %h want %h", rx[23:16], m_sr1 | 8'h03); end
    checks++; if (rx[7:0] !== rv) begin errors++; $display("FAIL poll_last: got %h want %h", rx[7:0], rv); end
    checks++; if (busy_len != BC) begin errors++; $display("FAIL busy_length: got %0d want %0d", busy_len, BC); end
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL poll_sr1_after: got %h want %h", sr1, m_sr1); end
  endtask

  task automatic test_no_wel();
    logic [63:0] rx; int ec, c0; logic cm; logic [7:0] rv;
    c0 = cmd_cnt;
    model_txn(64'h010C, 16, ec, cm, rv);
    spi_xfer(64'h010C, 16, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL nowel_sr1: got %h want %h", sr1, m_sr1); end
    checks++; if (sr2 !== m_sr2) begin errors++; $display("FAIL nowel_sr2: got %h want %h", sr2, m_sr2); end
    checks++; if (cmd_cnt - c0 != ec) begin errors++; $display("FAIL nowel_cmd_done: got %0d want %0d", cmd_cnt - c0, ec); end
  endtask

  task automatic test_wsr8();
    logic [63:0] rx; int ec; logic cm; logic [7:0] rv;
    model_txn(64'h06, 8, ec, cm, rv);
    spi_xfer(64'h06, 8, 5, rx);
    model_txn(64'h01FC, 16, ec, cm, rv);
    spi_xfer(64'h01FC, 16, 5, rx);
    checks++; if (sr1 !== (m_sr1 | 8'h03)) begin errors++; $display("FAIL wsr8_sr1_busy: got %h want %h", sr1, m_sr1 | 8'h03); end
    checks++; if (sr2 !== m_sr2) begin errors++; $display("FAIL wsr8_sr2: got %h want %h", sr2, m_sr2); end
    repeat (BC + 10) @(negedge ACLK);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL wsr8_sr1_settled: got %h want %h", sr1, m_sr1); end
  endtask

  task automatic test_wel_clear();
    logic [63:0] rx; int ec; logic cm; logic [7:0] rv;
    model_txn(64'h06, 8, ec, cm, rv);
    spi_xfer(64'h06, 8, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL welclr_set: got %h want %h", sr1, m_sr1); end
    model_txn(64'h04, 8, ec, cm, rv);
    spi_xfer(64'h04, 8, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL welclr_clear: got %h want %h", sr1, m_sr1); end
    model_txn(64'h013333, 24, ec, cm, rv);
    spi_xfer(64'h013333, 24, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL welclr_wsr_sr1: got %h want %h", sr1, m_sr1); end
    checks++; if (sr2 !== m_sr2) begin errors++; $display("FAIL welclr_wsr_sr2: got %h want %h", sr2, m_sr2); end
  endtask

  task automatic test_partial();
    logic [63:0] rx; int ec, c0, o0; logic cm; logic [7:0] rv;
    c0 = cmd_cnt; o0 = oe_cnt;
    model_txn(64'h00, 5, ec, cm, rv);
    spi_xfer(64'h00, 5, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL partial_sr1: got %h want %h", sr1, m_sr1); end
    checks++; if (cmd_cnt - c0 != 0) begin errors++; $display("FAIL partial_cmd_done: got %0d want 0", cmd_cnt - c0); end
    checks++; if (oe_cnt - o0 != 0) begin errors++; $display("FAIL partial_oe: got %0d want 0", oe_cnt - o0); end
  endtask

  task automatic test_busy_block();
    logic [63:0] rx; int ec, c0; logic cm; logic [7:0] rv;
    model_txn(64'h06, 8, ec, cm, rv);
    spi_xfer(64'h06, 8, 5, rx);
    model_txn(64'h01A5, 16, ec, cm, rv);
    spi_xfer(64'h01A5, 16, 5, rx);
    // Write Disable during BUSY is recognised but has no effect.
    c0 = cmd_cnt;
    spi_xfer(64'h04, 8, 4, rx);
    checks++; if (sr1 !== (m_sr1 | 8'h03)) begin errors++; $display("FAIL busy_wrdi_ignored: got %h want %h", sr1, m_sr1 | 8'h03); end
    checks++; if (cmd_cnt - c0 != 1) begin errors++; $display("FAIL busy_wrdi_cmd_done: got %0d want 1", cmd_cnt - c0); end
    repeat (BC + 10) @(negedge ACLK);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL busy_settled: got %h want %h", sr1, m_sr1); end
  endtask

  task automatic test_read_stream();
    logic [63:0] rx; int ec, o0; logic cm; logic [7:0] rv;
    o0 = oe_cnt;
    model_txn(64'h05000000, 32, ec, cm, rv);
    spi_xfer(64'h05000000, 32, 5, rx);
    checks++; if (rx[23:0] !== {rv, rv, rv}) begin errors++; $display("FAIL rdsr1_stream: got %h want %h", rx[23:0], {rv, rv, rv}); end
    checks++; if (oe_cnt - o0 == 0) begin errors++; $display("FAIL rdsr1_oe: got 0 cycles want nonzero"); end
    model_txn(64'h350000, 24, ec, cm, rv);
    spi_xfer(64'h350000, 24, 5, rx);
    checks++; if (rx[15:0] !== {rv, rv}) begin errors++; $display("FAIL rdsr2_stream: got %h want %h", rx[15:0], {rv, rv}); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rx; int ec, c0; logic cm; logic [7:0] rv;
    spi_begin(5);
    spi_bits(64'h05, 8, 5, rx);
    spi_bits(64'h00, 3, 5, rx);
    repeat (4) @(negedge ACLK);
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL midrst_oe_before: got %b want 1", miso_oe); end
    ARESETn = 1'b0;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe: got %b want 0", miso_oe); end
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    m_sr1 = 8'h00; m_sr2 = SR2I;
    repeat (3) @(negedge ACLK);
    // cs_n is still low: this Write Enable must be ignored.
    c0 = cmd_cnt;
    spi_bits(64'h06, 8, 5, rx);
    repeat (6) @(negedge ACLK);
    checks++; if (sr1 !== 8'h00) begin errors++; $display("FAIL midrst_wait_cs_sr1: got %h want 00", sr1); end
    checks++; if (sr2 !== SR2I) begin errors++; $display("FAIL midrst_sr2: got %h want %h", sr2, SR2I); end
    spi_end(5);
    checks++; if (cmd_cnt - c0 != 0) begin errors++; $display("FAIL midrst_cmd_done: got %0d want 0", cmd_cnt - c0); end
    model_txn(64'h06, 8, ec, cm, rv);
    spi_xfer(64'h06, 8, 5, rx);
    checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL midrst_recover: got %h want %h", sr1, m_sr1); end
  endtask

  task automatic test_random();
    logic [63:0] tx, rx; int ec, c0, sel, nbits, half; logic cm, is_rd; logic [7:0] rv, op;
    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 6);
      half = $urandom_range(4, 7);
      tx = {$urandom(), $urandom()};
      is_rd = 1'b0;
      case (sel)
        0: begin op = 8'h06; nbits = 8; end
        1: begin op = 8'h04; nbits = 8; end
        2: begin
          op = 8'h01;
          case ($urandom_range(0, 5))
            0: nbits = 8; 1: nbits = 13; 2: nbits = 16;
            3: nbits = 21; 4: nbits = 24; default: nbits = 29;
          endcase
        end
        3: begin op = 8'h05; nbits = 24; is_rd = 1'b1; end
        4: begin op = 8'h35; nbits = 24; is_rd = 1'b1; end
        5: begin op = 8'($urandom_range(0, 255)); nbits = 8; end
        default: begin op = 8'h00; nbits = $urandom_range(1, 7); end
      endcase
      if (nbits >= 8) tx[nbits-1 -: 8] = op;
      c0 = cmd_cnt;
      model_txn(tx, nbits, ec, cm, rv);
      spi_xfer(tx, nbits, half, rx);
      checks++; if (cmd_cnt - c0 != ec) begin errors++; $display("FAIL rand%0d_cmd_done: got %0d want %0d", it, cmd_cnt - c0, ec); end
      if (is_rd) begin
        checks++; if (rx[15:0] !== {rv, rv}) begin errors++; $display("FAIL rand%0d_read: got %h want %h", it, rx[15:0], {rv, rv}); end
      end
      if (cm) begin
        checks++; if (sr1 !== (m_sr1 | 8'h03)) begin errors++; $display("FAIL rand%0d_busy: got %h want %h", it, sr1, m_sr1 | 8'h03); end
        repeat (BC + 10) @(negedge ACLK);
      end
      checks++; if (sr1 !== m_sr1) begin errors++; $display("FAIL rand%0d_sr1: got %h want %h", it, sr1, m_sr1); end
      checks++; if (sr2 !== m_sr2) begin errors++; $display("FAIL rand%0d_sr2: got %h want %h", it, sr2, m_sr2); end
    end
  endtask

  initial begin
    test_reset();
    test_write_poll();
    test_no_wel();
    test_wsr8();
    test_wel_clear();
    test_partial();
    test_busy_block();
    test_read_stream();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
